// File: rtl/rv_decode_stage.sv
// RV32I decode stage: decodes one instruction per cycle into an execute
// bundle, with valid/ready handshakes on both sides and an optional
// one-entry skid buffer so in_ready_o can come straight from a flop.
module rv_decode_stage #(
  parameter int USE_SKID = 1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] instr_i,
  input  logic [31:0] pc_i,
  input  logic        flush_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [3:0]  alu_ctrl_o,
  output logic [4:0]  rs1_o,
  output logic [4:0]  rs2_o,
  output logic [4:0]  rd_o,
  output logic [31:0] imm_o,
  output logic        a_sel_pc_o,
  output logic        a_zero_o,
  output logic        b_sel_imm_o,
  output logic        reg_we_o,
  output logic        branch_o,
  output logic        branch_ne_o,
  output logic        illegal_o,
  output logic [31:0] pc_o
);

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;

  localparam logic [3:0] ALU_ADD = 4'd0;
  localparam logic [3:0] ALU_SUB = 4'd1;
  localparam logic [3:0] ALU_AND = 4'd2;
  localparam logic [3:0] ALU_OR  = 4'd3;
  localparam logic [3:0] ALU_XOR = 4'd4;
  localparam logic [3:0] ALU_SLL = 4'd5;
  localparam logic [3:0] ALU_SRL = 4'd6;
  localparam logic [3:0] ALU_SRA = 4'd7;

  typedef struct packed {
    logic [3:0]  alu_ctrl;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic        a_sel_pc;
    logic        a_zero;
    logic        b_sel_imm;
    logic        reg_we;
    logic        branch;
    logic        branch_ne;
    logic        illegal;
    logic [31:0] pc;
  } bundle_t;

  // Full combinational decode of one instruction word into a bundle.
  function automatic bundle_t decode(input logic [31:0] ins, input logic [31:0] pc);
    bundle_t    b;
    logic [2:0] f3;
    logic       is_imm;
    logic       std7;
    logic       alt7;
    logic [31:0] imm_i;
    f3     = ins[14:12];
    is_imm = (ins[6:0] == OPC_OPIMM);
    std7   = (ins[31:25] == 7'b0000000);
    alt7   = (ins[31:25] == 7'b0100000);
    imm_i  = {{20{ins[31]}}, ins[31:20]};
    b          = '0;
    b.rs1      = ins[19:15];
    b.rs2      = ins[24:20];
    b.rd       = ins[11:7];
    b.pc       = pc;
    b.alu_ctrl = ALU_ADD;
    case (ins[6:0])
      OPC_OP, OPC_OPIMM: begin
        b.reg_we    = 1'b1;
        b.b_sel_imm = is_imm;
        // Shift immediates carry only the zero-extended shamt.
        b.imm = (f3[1:0] == 2'b01) ? {27'd0, ins[24:20]} : imm_i;
        case (f3)
          3'b000: begin
            if (is_imm || std7) b.alu_ctrl = ALU_ADD;
            else if (alt7)      b.alu_ctrl = ALU_SUB;
            else                b.illegal  = 1'b1;
          end
          3'b001: begin
            if (std7) b.alu_ctrl = ALU_SLL;
            else      b.illegal  = 1'b1;
          end
          3'b100: begin
            if (is_imm || std7) b.alu_ctrl = ALU_XOR;
            else                b.illegal  = 1'b1;
          end
          3'b101: begin
            if (std7)      b.alu_ctrl = ALU_SRL;
            else if (alt7) b.alu_ctrl = ALU_SRA;
            else           b.illegal  = 1'b1;
          end
          3'b110: begin
            if (is_imm || std7) b.alu_ctrl = ALU_OR;
            else                b.illegal  = 1'b1;
          end
          3'b111: begin
            if (is_imm || std7) b.alu_ctrl = ALU_AND;
            else                b.illegal  = 1'b1;
          end
          default: b.illegal = 1'b1;
        endcase
      end
      OPC_LOAD, OPC_JALR: begin
        b.imm = imm_i; b.b_sel_imm = 1'b1; b.reg_we = 1'b1;
      end
      OPC_STORE: begin
        b.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; b.b_sel_imm = 1'b1;
      end
      OPC_LUI: begin
        b.imm = {ins[31:12], 12'd0}; b.a_zero = 1'b1; b.b_sel_imm = 1'b1; b.reg_we = 1'b1;
      end
      OPC_AUIPC: begin
        b.imm = {ins[31:12], 12'd0}; b.a_sel_pc = 1'b1; b.b_sel_imm = 1'b1; b.reg_we = 1'b1;
      end
      OPC_JAL: begin
        b.imm = {{12{ins[31]}}, ins[19:12], ins[20], ins[30:21], 1'b0};
        b.a_sel_pc = 1'b1; b.b_sel_imm = 1'b1; b.reg_we = 1'b1;
      end
      OPC_BRANCH: begin
        b.imm = {{20{ins[31]}}, ins[7], ins[30:25], ins[11:8], 1'b0};
        if (f3[2:1] == 2'b00) begin
          b.alu_ctrl  = ALU_SUB;
          b.branch    = 1'b1;
          b.branch_ne = f3[0];
        end else begin
          b.illegal = 1'b1;
        end
      end
      default: b.illegal = 1'b1;
    endcase
    // Illegal words still travel downstream, but must not side-effect.
    if (b.illegal) begin
      b.alu_ctrl  = ALU_ADD;
      b.reg_we    = 1'b0;
      b.branch    = 1'b0;
      b.branch_ne = 1'b0;
      b.a_sel_pc  = 1'b0;
      b.a_zero    = 1'b0;
      b.b_sel_imm = 1'b0;
    end
    return b;
  endfunction

  bundle_t bnd_p0;
  bundle_t bnd_p1;
  bundle_t skid_bnd;
  logic    vld_p1;
  logic    skid_vld;
  logic    in_fire;
  logic    load_out;

  // ---- stage p0: combinational decode of the offered word ----
  assign bnd_p0 = decode(instr_i, pc_i);

  assign in_ready_o = (USE_SKID != 0) ? !skid_vld : (!vld_p1 || out_ready_i);
  assign in_fire    = in_valid_i && in_ready_o && !flush_i;
  // Output register may take new data when empty or being consumed.
  assign load_out   = !vld_p1 || out_ready_i;

  // Valid bits: the only reset state; skid fills only while output stalls.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (flush_i) begin
      vld_p1   <= 1'b0;
      skid_vld <= 1'b0;
    end else if (load_out) begin
      vld_p1   <= skid_vld || in_fire;
      skid_vld <= 1'b0;
    end else if (in_fire && (USE_SKID != 0)) begin
      skid_vld <= 1'b1;
    end
  end

  // ---- stage p1: output and skid data registers (not reset) ----
  always_ff @(posedge clk_i) begin
    if (load_out) bnd_p1 <= skid_vld ? skid_bnd : bnd_p0;
    if (in_fire)  skid_bnd <= bnd_p0;
  end

  assign out_valid_o = vld_p1;
  assign alu_ctrl_o  = bnd_p1.alu_ctrl;
  assign rs1_o       = bnd_p1.rs1;
  assign rs2_o       = bnd_p1.rs2;
  assign rd_o        = bnd_p1.rd;
  assign imm_o       = bnd_p1.imm;
  assign a_sel_pc_o  = bnd_p1.a_sel_pc;
  assign a_zero_o    = bnd_p1.a_zero;
  assign b_sel_imm_o = bnd_p1.b_sel_imm;
  assign reg_we_o    = bnd_p1.reg_we;
  assign branch_o    = bnd_p1.branch;
  assign branch_ne_o = bnd_p1.branch_ne;
  assign illegal_o   = bnd_p1.illegal;
  assign pc_o        = bnd_p1.pc;

endmodule

// File: tb/tb_rv_decode_stage.sv
// Bench for rv_decode_stage: directed decode/backpressure/flush/reset cases
// plus a randomized run against a queue-based reference model.
module tb_rv_decode_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [31:0] instr_i;
  logic [31:0] pc_i;
  logic        flush_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [3:0]  alu_ctrl_o;
  logic [4:0]  rs1_o, rs2_o, rd_o;
  logic [31:0] imm_o;
  logic        a_sel_pc_o, a_zero_o, b_sel_imm_o, reg_we_o;
  logic        branch_o, branch_ne_o, illegal_o;
  logic [31:0] pc_o;

  always #5 clk_i = ~clk_i;

  rv_decode_stage #(.USE_SKID(1)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
    .instr_i(instr_i), .pc_i(pc_i), .flush_i(flush_i), .out_valid_o(out_valid_o),
    .out_ready_i(out_ready_i), .alu_ctrl_o(alu_ctrl_o), .rs1_o(rs1_o), .rs2_o(rs2_o),
    .rd_o(rd_o), .imm_o(imm_o), .a_sel_pc_o(a_sel_pc_o), .a_zero_o(a_zero_o),
    .b_sel_imm_o(b_sel_imm_o), .reg_we_o(reg_we_o), .branch_o(branch_o),
    .branch_ne_o(branch_ne_o), .illegal_o(illegal_o), .pc_o(pc_o)
  );

  // Flattened bundle: alu[89:86] rs1[85:81] rs2[80:76] rd[75:71] imm[70:39]
  // a_sel_pc[38] a_zero[37] b_sel_imm[36] reg_we[35] branch[34] branch_ne[33]
  // illegal[32] pc[31:0]
  typedef struct {
    logic [89:0] exp;
    logic [89:0] msk;
  } exp_t;

  exp_t        q[$];
  int          errors = 0;
  int          checks = 0;
  logic        last_acc = 1'b0;
  int          mdl_n;
  logic        mdl_acc;
  logic [89:0] act;

  assign act = {alu_ctrl_o, rs1_o, rs2_o, rd_o, imm_o, a_sel_pc_o, a_zero_o,
                b_sel_imm_o, reg_we_o, branch_o, branch_ne_o, illegal_o, pc_o};

  // What the decoder must produce for a word, from the ISA rules.
  function automatic exp_t model(input logic [31:0] w, input logic [31:0] pc);
    exp_t r;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic [3:0] alu;
    logic [31:0] imm;
    logic asp, az, bsi, we, br, bne, ill, imm_dc;
    op = w[6:0]; f3 = w[14:12]; f7 = w[31:25];
    alu = 0; imm = 0; asp = 0; az = 0; bsi = 0; we = 0; br = 0; bne = 0; ill = 0; imm_dc = 0;
    if (op == 7'h33 || op == 7'h13) begin
      case (f3)
        3'd0: alu = 0;  3'd1: alu = 5;  3'd4: alu = 4;
        3'd5: alu = 6;  3'd6: alu = 3;  3'd7: alu = 2;
        default: ill = 1;
      endcase
      if (!ill && (op == 7'h33 || f3 == 1 || f3 == 5)) begin
        if (f7 == 7'h20 && (f3 == 5 || (f3 == 0 && op == 7'h33))) alu = alu + 1;
        else if (f7 != 0) ill = 1;
      end
      we = 1;
      if (op == 7'h13) begin
        bsi = 1;
        imm = (f3 == 1 || f3 == 5) ? 32'(w[24:20]) : 32'($signed(w[31:20]));
      end else imm_dc = 1;
    end else if (op == 7'h03 || op == 7'h67) begin
      imm = 32'($signed(w[31:20])); bsi = 1; we = 1;
    end else if (op == 7'h23) begin
      imm = 32'($signed({w[31:25], w[11:7]})); bsi = 1;
    end else if (op == 7'h37) begin
      imm = {w[31:12], 12'h000}; az = 1; bsi = 1; we = 1;
    end else if (op == 7'h17) begin
      imm = {w[31:12], 12'h000}; asp = 1; bsi = 1; we = 1;
    end else if (op == 7'h6f) begin
      imm = 32'($signed({w[31], w[19:12], w[20], w[30:21], 1'b0})); asp = 1; bsi = 1; we = 1;
    end else if (op == 7'h63) begin
      imm = 32'($signed({w[31], w[7], w[30:25], w[11:8], 1'b0}));
      if (f3 == 0 || f3 == 1) begin alu = 1; br = 1; bne = f3[0]; end
      else ill = 1;
    end else ill = 1;
    if (ill) begin alu = 0; we = 0; br = 0; end
    r.exp = {alu, w[19:15], w[24:20], w[11:7], imm, asp, az, bsi, we, br, bne, ill, pc};
    r.msk = '1;
    if (imm_dc || ill) r.msk[70:39] = '0;
    if (ill) begin r.msk[38:36] = '0; r.msk[33] = 1'b0; end
    return r;
  endfunction

  // Reference model: FIFO of accepted-but-not-yet-consumed bundles (max 2).
  always @(posedge clk_i or posedge rst_i) begin
    if (rst_i || flush_i) begin
      q.delete();
      last_acc <= 1'b0;
    end else begin
      mdl_n   = q.size();
      mdl_acc = in_valid_i && (mdl_n < 2);
      if (mdl_n > 0 && out_ready_i) void'(q.pop_front());
      if (mdl_acc) q.push_back(model(instr_i, pc_i));
      last_acc <= mdl_acc;
    end
  end

  task automatic expect_eq(input string nm, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got 0x%08h, required 0x%08h at %0t", nm, a, e, $time);
    end
  endtask

  // Compare process: outputs vs model every cycle, away from the active edge.
  always @(negedge clk_i) begin
    expect_eq("out_valid", 32'(out_valid_o), 32'(q.size() != 0));
    expect_eq("in_ready", 32'(in_ready_o), 32'(q.size() < 2));
    if (q.size() != 0) begin
      checks++;
      if ((act & q[0].msk) !== (q[0].exp & q[0].msk)) begin
        errors++;
        $display("FAIL bundle: got 0x%023h, required 0x%023h (mask 0x%023h) at %0t",
                 act, q[0].exp, q[0].msk, $time);
      end
    end
  end

  function automatic logic [31:0] rnd_instr();
    logic [31:0] w;
    w = $urandom;
    case ($urandom % 10)
      0: w[6:0] = 7'h33;  1: w[6:0] = 7'h13;  2: w[6:0] = 7'h03;
      3: w[6:0] = 7'h23;  4: w[6:0] = 7'h67;  5: w[6:0] = 7'h37;
      6: w[6:0] = 7'h17;  7: w[6:0] = 7'h6f;  8: w[6:0] = 7'h63;
      default: ;
    endcase
    if (($urandom % 4) != 0) w[31:25] = (($urandom % 3) == 0) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic drain();
    @(negedge clk_i);
    in_valid_i = 0; flush_i = 0; out_ready_i = 1;
    repeat (3) @(negedge clk_i);
  endtask

  task automatic send_one(input logic [31:0] w);
    @(negedge clk_i);
    in_valid_i = 1; instr_i = w; pc_i = 32'h0000_1000; out_ready_i = 1;
    @(negedge clk_i);
    in_valid_i = 0;
  endtask

  task automatic fill_two(input logic [31:0] a, input logic [31:0] b);
    @(negedge clk_i);
    out_ready_i = 0; in_valid_i = 1; instr_i = a; pc_i = 32'h200;
    @(negedge clk_i);
    instr_i = b; pc_i = 32'h204;
    @(negedge clk_i);
    in_valid_i = 0;
  endtask

  logic [31:0] bp[3];
  logic [4:0]  got[$];
  int          idx;

  initial begin
    rst_i = 1; in_valid_i = 0; instr_i = 0; pc_i = 0; flush_i = 0; out_ready_i = 0;
    repeat (3) @(negedge clk_i);
    rst_i = 0;
    @(negedge clk_i);
    expect_eq("reset_out_valid", 32'(out_valid_o), 0);
    expect_eq("reset_in_ready", 32'(in_ready_o), 1);

    send_one(32'h002081B3);
    expect_eq("add_valid", 32'(out_valid_o), 1);
    expect_eq("add_alu", 32'(alu_ctrl_o), 0);
    expect_eq("add_rs1", 32'(rs1_o), 1);
    expect_eq("add_rs2", 32'(rs2_o), 2);
    expect_eq("add_rd", 32'(rd_o), 3);
    expect_eq("add_we", 32'(reg_we_o), 1);
    expect_eq("add_bsel", 32'(b_sel_imm_o), 0);
    drain();
    send_one(32'h402081B3);
    expect_eq("sub_alu", 32'(alu_ctrl_o), 1);
    drain();
    send_one(32'h40335293);
    expect_eq("srai_alu", 32'(alu_ctrl_o), 7);
    expect_eq("srai_imm", imm_o, 3);
    expect_eq("srai_bsel", 32'(b_sel_imm_o), 1);
    drain();
    send_one(32'hFFF00093);
    expect_eq("addi_imm", imm_o, 32'hFFFF_FFFF);
    expect_eq("addi_alu", 32'(alu_ctrl_o), 0);
    drain();
    send_one(32'h0020A1B3);
    expect_eq("slt_illegal", 32'(illegal_o), 1);
    expect_eq("slt_we", 32'(reg_we_o), 0);
    drain();
    send_one(32'h12345237);
    expect_eq("lui_imm", imm_o, 32'h1234_5000);
    expect_eq("lui_azero", 32'(a_zero_o), 1);
    drain();
    send_one(32'h00209463);
    expect_eq("bne_alu", 32'(alu_ctrl_o), 1);
    expect_eq("bne_branch", 32'(branch_o), 1);
    expect_eq("bne_ne", 32'(branch_ne_o), 1);
    expect_eq("bne_imm", imm_o, 8);
    drain();

    // Backpressure: three ADDIs to x10/x11/x12, output stalled 4 cycles.
    bp[0] = 32'h00100513; bp[1] = 32'h00100593; bp[2] = 32'h00100613;
    got.delete();
    @(negedge clk_i);
    out_ready_i = 0; in_valid_i = 1; instr_i = bp[0]; pc_i = 32'h300; idx = 0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk_i);
      if (in_valid_i && last_acc) idx++;
      in_valid_i = (idx < 3);
      if (idx < 3) instr_i = bp[idx];
      if (c == 1) expect_eq("bp_in_ready_low", 32'(in_ready_o), 0);
      if (c == 3) out_ready_i = 1;
      if (out_valid_o && out_ready_i) got.push_back(rd_o);
    end
    expect_eq("bp_count", 32'(got.size()), 3);
    for (int i = 0; i < 3; i++)
      expect_eq("bp_order", (i < got.size()) ? 32'(got[i]) : 32'hFFFF_FFFF, 32'(10 + i));
    drain();

    // Flush with a full skid; the word offered during flush is dropped.
    fill_two(32'h00100513, 32'h00100593);
    expect_eq("flush_pre_ready", 32'(in_ready_o), 0);
    flush_i = 1; in_valid_i = 1; instr_i = 32'h00100613;
    @(negedge clk_i);
    flush_i = 0; in_valid_i = 0;
    expect_eq("flush_out_valid", 32'(out_valid_o), 0);
    expect_eq("flush_in_ready", 32'(in_ready_o), 1);
    drain();

    // Asynchronous reset in the middle of a stall.
    fill_two(32'h00100513, 32'h00100593);
    #2 rst_i = 1;
    #1 expect_eq("rst_async_valid", 32'(out_valid_o), 0);
    @(negedge clk_i);
    @(negedge clk_i);
    rst_i = 0; out_ready_i = 1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk_i);
      expect_eq("rst_no_stale", 32'(out_valid_o), 0);
    end

    // Randomized traffic with backpressure and occasional flushes.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      if (!in_valid_i || last_acc) begin
        in_valid_i = ($urandom % 4) != 0;
        instr_i    = rnd_instr();
        pc_i       = $urandom & 32'hFFFF_FFFC;
      end
      out_ready_i = ($urandom % 3) != 0;
      flush_i     = ($urandom % 40) == 0;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
